// File: rtl/fp_quotient_rounder_pkg.sv
// Shared constants and types for the quotient rounder.
// Float field layout, exponent limits, default modulus and width.
package fp_coeff_pkg;

  localparam logic [7:0] EXP_BIAS    = 8'd127;
  localparam logic [7:0] EXP_SPECIAL = 8'd255;
  localparam logic [7:0] MAX_INT_EXP = 8'd157;

  localparam int DEF_Q       = 3329;
  localparam int DEF_COEFF_W = 12;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  function automatic fp32_t unpack(
    input logic [31:0] bits
  );
    return fp32_t'(bits);
  endfunction

endpackage

// File: rtl/fp_quotient_rounder_if.sv
// Coefficient output stream: data/valid from the rounder,
// ready from the consumer (master = producer side).
interface fp_quotient_rounder_if #(
  parameter int COEFF_W = 12
);
  logic [COEFF_W-1:0] coeff_data;
  logic               coeff_valid;
  logic               coeff_ready;

  modport master (
    output coeff_data,
    output coeff_valid,
    input  coeff_ready
  );

  modport slave (
    input  coeff_data,
    input  coeff_valid,
    output coeff_ready
  );
endinterface

// File: rtl/fp_quotient_rounder_coeff_fifo.sv
// Synchronous FIFO with occupancy count and drop-on-full.
// Ports: push/push_data in, data/valid/ready out, count, drop.
module coeff_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     ready,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             pop;
  logic             accept;

  assign full   = count == (AW+1)'(DEPTH);
  assign valid  = count != '0;
  assign pop    = valid & ready;
  // a full FIFO still takes the entry when
  // the head leaves in the same cycle
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign data   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + (AW+1)'(accept)
             - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/fp_quotient_rounder.sv
// Rounds divider quotients to integers, reduces mod Q, buffers.
// Ports: clock/reset_n, div_result+strobe in, coeff stream out, flags.
module fp_quotient_rounder
  import fp_coeff_pkg::*;
#(
  parameter int Q          = DEF_Q,
  parameter int COEFF_W    = DEF_COEFF_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [31:0]                   div_result,
  input  logic                          result_ready,
  input  logic                          flag_clear,
  fp_quotient_rounder_if.master         coeff,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          invalid
);

  fp32_t        s1_fp;
  logic         s1_valid;
  logic [4:0]   sh;
  logic [32:0]  fix;
  logic [31:0]  m_rnd;
  logic [31:0]  m_next;
  logic         bad;

  logic         s2_valid;
  logic         s2_sign;
  logic [31:0]  s2_m;
  logic [31:0]  rem;
  logic [COEFF_W-1:0] red;
  logic         drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_fp    <= '0;
    end else begin
      s1_valid <= result_ready;
      if (result_ready) s1_fp <= unpack(div_result);
    end
  end

  // fix[32:1] = floor(|x|), fix[0] = first fraction bit
  assign sh  = 5'(s1_fp.exp - EXP_BIAS);
  assign fix = 33'(({31'b0, 1'b1, s1_fp.frac} << sh) >> 22);
  assign m_rnd = fix[32:1] + {31'b0, fix[0]};

  always_comb begin
    m_next = '0;
    bad    = 1'b0;
    unique case (1'b1)
      (s1_fp.exp > MAX_INT_EXP): bad = 1'b1;
      (s1_fp.exp >= EXP_BIAS &&
       s1_fp.exp <= MAX_INT_EXP): m_next = m_rnd;
      (s1_fp.exp == EXP_BIAS - 8'd1): m_next = 32'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_m     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_fp.sign;
        s2_m    <= m_next;
      end
    end
  end

  // negative values fold to Q - r; -0 stays 0
  assign rem = s2_m % 32'(Q);
  assign red = COEFF_W'((s2_sign && rem != '0)
                        ? 32'(Q) - rem : rem);

  coeff_fifo #(
    .WIDTH (COEFF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (s2_valid),
    .push_data (red),
    .ready     (coeff.coeff_ready),
    .data      (coeff.coeff_data),
    .valid     (coeff.coeff_valid),
    .count     (fifo_count),
    .drop      (drop)
  );

  // a new event in the clear cycle keeps the flag set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      overflow <= (overflow & ~flag_clear) | drop;
      invalid  <= (invalid & ~flag_clear)
                | (s1_valid & bad);
    end
  end

endmodule

// File: tb/tb_fp_quotient_rounder.sv
// Self-checking bench for fp_quotient_rounder.
// Directed spec cases plus randomized stream vs real-number model.
module tb_fp_quotient_rounder;
  localparam int Q  = 3329;
  localparam int CW = 12;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] div_result = '0;
  logic        result_ready = 1'b0;
  logic        flag_clear = 1'b0;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        invalid;

  int total = 0;
  int bad = 0;

  fp_quotient_rounder_if #(.COEFF_W(CW)) cif();

  fp_quotient_rounder #(
    .Q(Q), .COEFF_W(CW), .FIFO_DEPTH(8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .div_result   (div_result),
    .result_ready (result_ready),
    .flag_clear   (flag_clear),
    .coeff        (cif),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .invalid      (invalid)
  );

  always #5 clock = ~clock;

  // value from IEEE fields with real arithmetic, round half away
  function automatic void ref_model(
    input  logic [31:0] b,
    output int          c,
    output bit          inv
  );
    int     e;
    real    mag;
    longint m;
    longint v;
    e = int'(b[30:23]);
    inv = 1'b0;
    m = 0;
    if (e == 255) inv = 1'b1;
    else if (e != 0) begin
      mag = (1.0 + real'(b[22:0]) / 8388608.0)
            * (2.0 ** (e - 127));
      if (mag >= 2147483648.0) inv = 1'b1;
      else m = longint'($floor(mag + 0.5));
    end
    v = b[31] ? -m : m;
    c = int'(((v % Q) + Q) % Q);
  endfunction

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (cif.coeff_valid !== 1'b0 || cif.coeff_data !== '0 ||
        fifo_count !== '0 || overflow !== 1'b0 ||
        invalid !== 1'b0) begin
      bad++;
      $display("FAIL reset: v=%b d=%0d cnt=%0d ov=%b inv=%b want 0",
               cif.coeff_valid, cif.coeff_data, fifo_count,
               overflow, invalid);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single;
    @(negedge clock);
    div_result = 32'h40200000;
    result_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      result_ready = 1'b0;
      total++;
      if (i == 3) begin
        if (cif.coeff_valid !== 1'b1 || cif.coeff_data !== 12'd3) begin
          bad++;
          $display("FAIL single_2p5: v=%b d=%0d want v=1 d=3",
                   cif.coeff_valid, cif.coeff_data);
        end
      end else if (cif.coeff_valid !== 1'b0) begin
        bad++;
        $display("FAIL single_timing c%0d: v=%b want 0",
                 i, cif.coeff_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vin [4];
    int          want [4];
    vin[0] = 32'hBF800000; want[0] = 3328;
    vin[1] = 32'hC0200000; want[1] = 3326;
    vin[2] = 32'h3F000000; want[2] = 1;
    vin[3] = 32'h3E800000; want[3] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i >= 3 && i < 7) begin
        total++;
        if (cif.coeff_valid !== 1'b1 ||
            int'(cif.coeff_data) != want[i-3]) begin
          bad++;
          $display("FAIL b2b[%0d]: v=%b d=%0d want %0d",
                   i-3, cif.coeff_valid, cif.coeff_data, want[i-3]);
        end
      end
      if (i == 7) begin
        total++;
        if (cif.coeff_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_end: v=%b want 0", cif.coeff_valid);
        end
      end
      result_ready = i < 4;
      if (i < 4) div_result = vin[i];
    end
  endtask

  task automatic test_large;
    @(negedge clock);
    div_result = 32'h45DAC000;
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (cif.coeff_valid !== 1'b1 || cif.coeff_data !== 12'd342) begin
      bad++;
      $display("FAIL large_7000: v=%b d=%0d want 342",
               cif.coeff_valid, cif.coeff_data);
    end
  endtask

  task automatic test_nan;
    @(negedge clock);
    div_result = 32'h7FC00000;
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    total++;
    if (invalid !== 1'b0) begin
      bad++;
      $display("FAIL nan_early: inv=%b want 0", invalid);
    end
    @(negedge clock);
    total++;
    if (invalid !== 1'b1) begin
      bad++;
      $display("FAIL nan_inv: inv=%b want 1", invalid);
    end
    @(negedge clock);
    total++;
    if (cif.coeff_valid !== 1'b1 || cif.coeff_data !== '0) begin
      bad++;
      $display("FAIL nan_data: v=%b d=%0d want 0",
               cif.coeff_valid, cif.coeff_data);
    end
    flag_clear = 1'b1;
    @(negedge clock);
    flag_clear = 1'b0;
    total++;
    if (invalid !== 1'b0) begin
      bad++;
      $display("FAIL nan_clear: inv=%b want 0", invalid);
    end
  endtask

  task automatic test_overflow;
    int got;
    @(negedge clock);
    cif.coeff_ready = 1'b0;
    div_result = 32'h3F800000;
    for (int i = 0; i < 9; i++) begin
      result_ready = 1'b1;
      @(negedge clock);
    end
    result_ready = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_full: cnt=%0d ov=%b want 8/1",
               fifo_count, overflow);
    end
    got = 0;
    cif.coeff_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cif.coeff_valid) begin
        got++;
        total++;
        if (cif.coeff_data !== 12'd1) begin
          bad++;
          $display("FAIL ovf_data: d=%0d want 1", cif.coeff_data);
        end
      end
      @(negedge clock);
    end
    total++;
    if (got != 8 || fifo_count !== '0) begin
      bad++;
      $display("FAIL ovf_drain: got=%0d cnt=%0d want 8/0",
               got, fifo_count);
    end
    flag_clear = 1'b1;
    @(negedge clock);
    flag_clear = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: ov=%b want 0", overflow);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    div_result = 32'h40200000;
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if (cif.coeff_valid !== 1'b0 || fifo_count !== '0) begin
        bad++;
        $display("FAIL rst_mid c%0d: v=%b cnt=%0d want 0/0",
                 i, cif.coeff_valid, fifo_count);
      end
    end
    div_result = 32'h40000000;
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (cif.coeff_valid !== 1'b1 || cif.coeff_data !== 12'd2) begin
      bad++;
      $display("FAIL rst_after: v=%b d=%0d want 2",
               cif.coeff_valid, cif.coeff_data);
    end
  endtask

  task automatic test_random;
    int          q[$];
    int          c;
    int          want;
    int          e;
    bit          inv;
    bit          inv_seen;
    logic [31:0] b;
    inv_seen = 1'b0;
    @(negedge clock);
    flag_clear = 1'b1;
    @(negedge clock);
    flag_clear = 1'b0;
    for (int k = 0; k < 400; k++) begin
      cif.coeff_ready = (k % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (cif.coeff_valid && cif.coeff_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra: d=%0d want none", cif.coeff_data);
        end else begin
          want = q.pop_front();
          if (int'(cif.coeff_data) != want) begin
            bad++;
            $display("FAIL rnd_data: d=%0d want %0d",
                     cif.coeff_data, want);
          end
        end
      end
      result_ready = 1'b0;
      if (k < 360 && k % 2 == 0 && $urandom_range(0, 3) != 0) begin
        e = $urandom_range(0, 15);
        b[31]    = 1'($urandom_range(0, 1));
        b[22:0]  = 23'($urandom);
        b[30:23] = (e == 0) ? 8'd0 :
                   (e == 1) ? 8'd255 :
                   (e == 2) ? 8'($urandom_range(158, 163)) :
                              8'($urandom_range(118, 157));
        ref_model(b, c, inv);
        q.push_back(c);
        inv_seen |= inv;
        div_result = b;
        result_ready = 1'b1;
      end
      @(negedge clock);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL rnd_timeout: left=%0d want 0", q.size());
    end
    total++;
    if (invalid !== inv_seen || overflow !== 1'b0) begin
      bad++;
      $display("FAIL rnd_flags: inv=%b ov=%b want %b/0",
               invalid, overflow, inv_seen);
    end
  endtask

  initial begin
    cif.coeff_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_large();
    test_nan();
    test_overflow();
    cif.coeff_ready = 1'b1;
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
